hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipeline_pkg.sv | 42 ++++
 rtl/fwd_unit.sv | 24 ++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard FSM states, forwarding selects, stall/flush control bundle.
package pipeline_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic pc_stop;
    logic if_id_stop;
    logic id_ex_stop;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE = '0;

  // Load-use bubble: freeze the front end and turn ID/EX into a bubble.
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{pc_stop: 1'b1, if_id_stop: 1'b1, id_ex_stop: 1'b0,
                                           if_id_flush: 1'b0, id_ex_flush: 1'b1};

  localparam pipe_ctrl_t CTRL_MEM_HOLD = '{pc_stop: 1'b1, if_id_stop: 1'b1, id_ex_stop: 1'b1,
                                           if_id_flush: 1'b0, id_ex_flush: 1'b0};

  localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_stop: 1'b0, if_id_stop: 1'b0, id_ex_stop: 1'b0,
                                           if_id_flush: 1'b1, id_ex_flush: 1'b1};

  // x0 is hard-wired to zero, so a write to it never produces a value worth forwarding.
  function automatic logic reg_match(input logic [REG_AW-1:0] rd, input logic we,
                                     input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register; the nearest producer (MEM) wins over WB.
module fwd_unit
  import pipeline_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);

  // NOTE: every branch of a combinational block must assign its outputs; the default
  // assignment at the top is what keeps synthesis from inferring a latch.
  always_comb begin
    sel = FWD_RF;
    if (reg_match(mem_rd, mem_we, rs)) begin
      sel = FWD_MEM;
    end else if (reg_match(wb_rd, wb_we, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait hold, redirect flush, forwarding.
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int LD_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_rs1_i,
  input  logic [REG_AW-1:0] ID_rs2_i,
  input  logic              ID_rs1_used_i,
  input  logic              ID_rs2_used_i,
  input  logic [REG_AW-1:0] EX_rd_i,
  input  logic              EX_RFwe_i,
  input  logic              EX_load_i,
  input  logic [REG_AW-1:0] MEM_rd_i,
  input  logic              MEM_RFwe_i,
  input  logic [REG_AW-1:0] WB_rd_i,
  input  logic              WB_RFwe_i,
  input  logic              EX_redirect_i,
  input  logic              DM_busy_i,
  output logic              PC_stop_o,
  output logic              IF_ID_stop_o,
  output logic              ID_EX_stop_o,
  output logic              IF_ID_flush_o,
  output logic              ID_EX_flush_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic [1:0]        state_o
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  if (LD_BUBBLES < 1 || LD_BUBBLES > 3 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl: LD_BUBBLES must be 1..3 and CNT_W at least 1");
  end

  // First LDSTALL cycle follows the RUN cycle that detected the hazard, so it
  // starts one below the total bubble count.
  localparam logic [1:0] BUB_INIT = 2'(LD_BUBBLES - 1);

  hz_state_e  state_q, state_d;
  logic [1:0] bub_q, bub_d;
  pipe_ctrl_t ctrl;
  logic       load_use;
  logic [1:0] sel_a, sel_b;

  assign load_use = EX_load_i && EX_RFwe_i && (EX_rd_i != '0) &&
                    ((ID_rs1_used_i && (ID_rs1_i == EX_rd_i)) ||
                     (ID_rs2_used_i && (ID_rs2_i == EX_rd_i)));

  always_comb begin
    ctrl    = CTRL_NONE;
    state_d = state_q;
    bub_d   = bub_q;
    if (rst) begin
      state_d = ST_RUN;
      bub_d   = '0;
    end else if (DM_busy_i) begin
      ctrl    = CTRL_MEM_HOLD;
      state_d = ST_MEMWAIT;
      bub_d   = '0;
    end else if (EX_redirect_i) begin
      // The redirected path discards the stalled instruction, so pending bubbles go too.
      ctrl    = CTRL_REDIRECT;
      state_d = ST_RUN;
      bub_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use) begin
            ctrl = CTRL_LOAD_USE;
            if (LD_BUBBLES > 1) begin
              state_d = ST_LDSTALL;
              bub_d   = BUB_INIT;
            end
          end
        end
        ST_LDSTALL: begin
          ctrl = CTRL_LOAD_USE;
          if (bub_q <= 2'd1) begin
            state_d = ST_RUN;
            bub_d   = '0;
          end else begin
            bub_d = bub_q - 2'd1;
          end
        end
        ST_MEMWAIT: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          bub_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  fwd_unit u_fwd_a (
    .rs     (ID_rs1_i),
    .mem_rd (MEM_rd_i),
    .mem_we (MEM_RFwe_i),
    .wb_rd  (WB_rd_i),
    .wb_we  (WB_RFwe_i),
    .sel    (sel_a)
  );

  fwd_unit u_fwd_b (
    .rs     (ID_rs2_i),
    .mem_rd (MEM_rd_i),
    .mem_we (MEM_RFwe_i),
    .wb_rd  (WB_rd_i),
    .wb_we  (WB_RFwe_i),
    .sel    (sel_b)
  );

  assign PC_stop_o     = ctrl.pc_stop;
  assign IF_ID_stop_o  = ctrl.if_id_stop;
  assign ID_EX_stop_o  = ctrl.id_ex_stop;
  assign IF_ID_flush_o = ctrl.if_id_flush;
  assign ID_EX_flush_o = ctrl.id_ex_flush;
  assign fwd_a_sel_o   = rst ? FWD_RF : sel_a;
  assign fwd_b_sel_o   = rst ? FWD_RF : sel_b;
  assign state_o       = state_q;

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (ctrl.pc_stop)     stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (ctrl.if_id_flush) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`else
  // Without the counters the controller is purely the FSM and forwarding logic above.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one instance with LD_BUBBLES=1, one with LD_BUBBLES=3.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs1_i, ID_rs2_i, EX_rd_i, MEM_rd_i, WB_rd_i;
  logic       ID_rs1_used_i, ID_rs2_used_i, EX_RFwe_i, EX_load_i;
  logic       MEM_RFwe_i, WB_RFwe_i, EX_redirect_i, DM_busy_i;

  logic       pc1, ifs1, ies1, iff1, ief1;
  logic       pc3, ifs3, ies3, iff3, ief3;
  logic [1:0] fa1, fb1, st1, fa3, fb3, st3;
`ifdef HAZARD_CTRL_PERF_EN
  logic [3:0] sc1, fc1, sc3, fc3;
`endif

  hazard_ctrl #(.LD_BUBBLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_rs1_used_i(ID_rs1_used_i), .ID_rs2_used_i(ID_rs2_used_i),
    .EX_rd_i(EX_rd_i), .EX_RFwe_i(EX_RFwe_i), .EX_load_i(EX_load_i),
    .MEM_rd_i(MEM_rd_i), .MEM_RFwe_i(MEM_RFwe_i),
    .WB_rd_i(WB_rd_i), .WB_RFwe_i(WB_RFwe_i),
    .EX_redirect_i(EX_redirect_i), .DM_busy_i(DM_busy_i),
    .PC_stop_o(pc1), .IF_ID_stop_o(ifs1), .ID_EX_stop_o(ies1),
    .IF_ID_flush_o(iff1), .ID_EX_flush_o(ief1),
    .fwd_a_sel_o(fa1), .fwd_b_sel_o(fb1), .state_o(st1)
`ifdef HAZARD_CTRL_PERF_EN
    , .stall_cnt_o(sc1), .flush_cnt_o(fc1)
`endif
  );

  hazard_ctrl #(.LD_BUBBLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst),
    .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
    .ID_rs1_used_i(ID_rs1_used_i), .ID_rs2_used_i(ID_rs2_used_i),
    .EX_rd_i(EX_rd_i), .EX_RFwe_i(EX_RFwe_i), .EX_load_i(EX_load_i),
    .MEM_rd_i(MEM_rd_i), .MEM_RFwe_i(MEM_RFwe_i),
    .WB_rd_i(WB_rd_i), .WB_RFwe_i(WB_RFwe_i),
    .EX_redirect_i(EX_redirect_i), .DM_busy_i(DM_busy_i),
    .PC_stop_o(pc3), .IF_ID_stop_o(ifs3), .ID_EX_stop_o(ies3),
    .IF_ID_flush_o(iff3), .ID_EX_flush_o(ief3),
    .fwd_a_sel_o(fa3), .fwd_b_sel_o(fb3), .state_o(st3)
`ifdef HAZARD_CTRL_PERF_EN
    , .stall_cnt_o(sc3), .flush_cnt_o(fc3)
`endif
  );

  always #5 clk = ~clk;

  // Control bundle order: {PC_stop, IF_ID_stop, ID_EX_stop, IF_ID_flush, ID_EX_flush}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11001;
  localparam logic [4:0] C_MEM  = 5'b11100;
  localparam logic [4:0] C_RD   = 5'b00011;

  typedef struct packed {
    logic [4:0] c1;
    logic [1:0] s1;
    logic [4:0] c3;
    logic [1:0] s3;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are compared at the falling edge, mid-cycle, against the entry queued
  // when that cycle's stimulus was applied; state is the value held during the cycle.
  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, "/ctrl1"}, 32'({pc1, ifs1, ies1, iff1, ief1}), 32'(e.c1));
      check({t, "/state1"}, 32'(st1), 32'(e.s1));
      check({t, "/ctrl3"}, 32'({pc3, ifs3, ies3, iff3, ief3}), 32'(e.c3));
      check({t, "/state3"}, 32'(st3), 32'(e.s3));
      check({t, "/fwd_a1"}, 32'(fa1), 32'(e.fa));
      check({t, "/fwd_b1"}, 32'(fb1), 32'(e.fb));
      check({t, "/fwd_a3"}, 32'(fa3), 32'(e.fa));
      check({t, "/fwd_b3"}, 32'(fb3), 32'(e.fb));
    end
  end

  task automatic step(input string tag, input logic [4:0] c1, input logic [1:0] s1,
                      input logic [4:0] c3, input logic [1:0] s3,
                      input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e = '{c1: c1, s1: s1, c3: c3, s3: s3, fa: fa, fb: fb};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Load in EX writing x5 while the ID instruction reads x5 through rs1.
  task automatic set_hz(input logic on);
    EX_load_i     = on;
    EX_RFwe_i     = on;
    EX_rd_i       = on ? 5'd5 : 5'd0;
    ID_rs1_i      = 5'd5;
    ID_rs1_used_i = 1'b1;
  endtask

  task automatic clear_fwd();
    MEM_rd_i   = 5'd0;
    MEM_RFwe_i = 1'b0;
    WB_rd_i    = 5'd0;
    WB_RFwe_i  = 1'b0;
    ID_rs2_i   = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    ID_rs1_i = '0; ID_rs2_i = '0; ID_rs1_used_i = 1'b0; ID_rs2_used_i = 1'b0;
    EX_rd_i = '0; EX_RFwe_i = 1'b0; EX_load_i = 1'b0;
    MEM_rd_i = '0; MEM_RFwe_i = 1'b0; WB_rd_i = '0; WB_RFwe_i = 1'b0;
    EX_redirect_i = 1'b0; DM_busy_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset suppresses every stop/flush and forwarding even with all triggers present.
    set_hz(1'b1);
    DM_busy_i = 1'b1; EX_redirect_i = 1'b1;
    ID_rs2_i = 5'd7; MEM_rd_i = 5'd7; MEM_RFwe_i = 1'b1; WB_rd_i = 5'd5; WB_RFwe_i = 1'b1;
    step("rst", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);
    rst = 1'b0; DM_busy_i = 1'b0; EX_redirect_i = 1'b0;
    clear_fwd();

    // Load-use: single bubble vs three bubbles (state 0, then 1, 1, then back to 0).
    step("ld_use", C_LU, 2'd0, C_LU, 2'd0, 2'b00, 2'b00);
    set_hz(1'b0);
    step("ld_b2", C_NONE, 2'd0, C_LU, 2'd1, 2'b00, 2'b00);
    step("ld_b3", C_NONE, 2'd0, C_LU, 2'd1, 2'b00, 2'b00);
    step("ld_done", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);

    // Redirect while in LDSTALL discards the remaining bubbles.
    set_hz(1'b1);
    step("ra_hz", C_LU, 2'd0, C_LU, 2'd0, 2'b00, 2'b00);
    EX_redirect_i = 1'b1;
    step("ra_redir", C_RD, 2'd0, C_RD, 2'd1, 2'b00, 2'b00);
    EX_redirect_i = 1'b0;
    set_hz(1'b0);
    step("ra_after", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);

    // Memory wait outranks both redirect and load-use.
    set_hz(1'b1);
    DM_busy_i = 1'b1; EX_redirect_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("mw%0d", i), C_MEM, (i == 0) ? 2'd0 : 2'd2,
           C_MEM, (i == 0) ? 2'd0 : 2'd2, 2'b00, 2'b00);
    end
    DM_busy_i = 1'b0; EX_redirect_i = 1'b0;
    set_hz(1'b0);
    step("mw_exit", C_NONE, 2'd2, C_NONE, 2'd2, 2'b00, 2'b00);
    step("mw_run", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);

    // Forwarding priority and the x0 rule.
    ID_rs1_i = 5'd0; ID_rs2_i = 5'd7;
    MEM_rd_i = 5'd7; MEM_RFwe_i = 1'b1; WB_rd_i = 5'd7; WB_RFwe_i = 1'b1;
    step("fwd_mem", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b01);
    MEM_RFwe_i = 1'b0;
    step("fwd_wb", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b10);
    ID_rs2_i = 5'd0; MEM_rd_i = 5'd0; MEM_RFwe_i = 1'b1; WB_rd_i = 5'd0;
    step("fwd_x0", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);
    ID_rs1_i = 5'd3; ID_rs2_i = 5'd4; MEM_rd_i = 5'd4; WB_rd_i = 5'd3;
    step("fwd_ab", C_NONE, 2'd0, C_NONE, 2'd0, 2'b10, 2'b01);
    clear_fwd();

    // Reset in the middle of LDSTALL abandons the stall immediately.
    set_hz(1'b1);
    step("rs_hz", C_LU, 2'd0, C_LU, 2'd0, 2'b00, 2'b00);
    rst = 1'b1;
    step("rs_mid", C_NONE, 2'd0, C_NONE, 2'd1, 2'b00, 2'b00);
    rst = 1'b0;
    set_hz(1'b0);
    step("rs_after", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);

    // Counter run: 17 stall cycles wrap a 4-bit counter to 1, then two flushes, then reset.
    rst = 1'b1;
    step("pf_rst", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);
    rst = 1'b0;
    DM_busy_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step("pf_busy", C_MEM, (i == 0) ? 2'd0 : 2'd2,
           C_MEM, (i == 0) ? 2'd0 : 2'd2, 2'b00, 2'b00);
    end
    DM_busy_i = 1'b0;
    step("pf_exit", C_NONE, 2'd2, C_NONE, 2'd2, 2'b00, 2'b00);
`ifdef HAZARD_CTRL_PERF_EN
    check("pf_stall1", 32'(sc1), 32'd1);
    check("pf_stall3", 32'(sc3), 32'd1);
    check("pf_flush1_zero", 32'(fc1), 32'd0);
`endif
    EX_redirect_i = 1'b1;
    step("pf_redir0", C_RD, 2'd0, C_RD, 2'd0, 2'b00, 2'b00);
    step("pf_redir1", C_RD, 2'd0, C_RD, 2'd0, 2'b00, 2'b00);
    EX_redirect_i = 1'b0;
`ifdef HAZARD_CTRL_PERF_EN
    check("pf_flush1", 32'(fc1), 32'd2);
    check("pf_flush3", 32'(fc3), 32'd2);
    check("pf_stall_hold", 32'(sc1), 32'd1);
`endif
    rst = 1'b1;
    step("pf_rst2", C_NONE, 2'd0, C_NONE, 2'd0, 2'b00, 2'b00);
    rst = 1'b0;
`ifdef HAZARD_CTRL_PERF_EN
    check("pf_stall_clr", 32'(sc1), 32'd0);
    check("pf_flush_clr", 32'(fc3), 32'd0);
`endif

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
